// File: rtl/gate_test_sequencer_if.sv
// Memory-port bundle between the gate-test sequencer (master) and the shared
// byte memory (slave). Request/acknowledge handshake with one-cycle ack.
interface gate_test_sequencer_if;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ack;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    input  mem_ack
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    output mem_ack
  );
endinterface

// File: rtl/gate_test_sequencer.sv
// Gate-test sequencer: reads each input vector from memory, drives it onto the
// device pins, waits SETTLE_CYCLES, then writes the sampled device outputs to
// the result region. All outputs come straight from registers.
module gate_test_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic                         abort,
  input  logic [15:0]                  in_start_addr,
  input  logic [15:0]                  in_end_addr,
  input  logic [15:0]                  out_start_addr,
  gate_test_sequencer_if.master        mem_if,
  output logic [7:0]                   dut_in,
  input  logic [7:0]                   dut_out,
  output logic                         busy,
  output logic                         done,
  output logic                         err,
  output logic [15:0]                  vec_count
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WRITE  = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] rd_ptr_q, rd_ptr_d;
  logic [15:0] wr_ptr_q, wr_ptr_d;
  logic [15:0] end_ptr_q, end_ptr_d;
  logic [7:0]  settle_cnt_q, settle_cnt_d;
  logic [7:0]  dut_in_q, dut_in_d;
  logic [15:0] vec_count_q, vec_count_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  // State, datapath and output registers; async reset drops mem_req immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      rd_ptr_q     <= 16'h0000;
      wr_ptr_q     <= 16'h0000;
      end_ptr_q    <= 16'h0000;
      settle_cnt_q <= 8'h00;
      dut_in_q     <= 8'h00;
      vec_count_q  <= 16'h0000;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      end_ptr_q    <= end_ptr_d;
      settle_cnt_q <= settle_cnt_d;
      dut_in_q     <= dut_in_d;
      vec_count_q  <= vec_count_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
    end
  end

  // Next-state and datapath updates; abort overrides any pending update.
  always_comb begin
    state_d      = state_q;
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    end_ptr_d    = end_ptr_q;
    settle_cnt_d = settle_cnt_q;
    dut_in_d     = dut_in_q;
    vec_count_d  = vec_count_q;
    mem_wdata_d  = mem_wdata_q;
    err_d        = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (in_end_addr >= in_start_addr) begin
            rd_ptr_d    = in_start_addr;
            wr_ptr_d    = out_start_addr;
            end_ptr_d   = in_end_addr;
            vec_count_d = 16'h0000;
            state_d     = ST_READ;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        if (mem_if.mem_ack) begin
          dut_in_d     = mem_if.mem_rdata;
          settle_cnt_d = SETTLE_LOAD;
          state_d      = ST_SETTLE;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == 8'd1) begin
          mem_wdata_d = dut_out;
          state_d     = ST_WRITE;
        end else begin
          settle_cnt_d = settle_cnt_q - 8'd1;
        end
      end
      ST_WRITE: begin
        if (mem_if.mem_ack) begin
          vec_count_d = vec_count_q + 16'd1;
          // Compare before incrementing so an end address of 0xFFFF stops cleanly.
          if (rd_ptr_q == end_ptr_q) begin
            state_d = ST_DONE;
          end else begin
            rd_ptr_d = rd_ptr_q + 16'd1;
            wr_ptr_d = wr_ptr_q + 16'd1;
            state_d  = ST_READ;
          end
        end else begin
          state_d = ST_WRITE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Abort discards whatever the current state (including an ack) would have done.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      rd_ptr_d     = rd_ptr_q;
      wr_ptr_d     = wr_ptr_q;
      end_ptr_d    = end_ptr_q;
      settle_cnt_d = settle_cnt_q;
      dut_in_d     = dut_in_q;
      vec_count_d  = vec_count_q;
      mem_wdata_d  = mem_wdata_q;
    end else begin
      err_d = err_d;
    end
  end

  // Registered outputs decoded from the next state, so they align with it.
  always_comb begin
    mem_req_d  = (state_d == ST_READ) || (state_d == ST_WRITE);
    mem_we_d   = (state_d == ST_WRITE);
    busy_d     = (state_d != ST_IDLE);
    done_d     = (state_d == ST_DONE);
    mem_addr_d = mem_addr_q;
    if (state_d == ST_WRITE) begin
      mem_addr_d = wr_ptr_d;
    end else if (state_d == ST_READ) begin
      mem_addr_d = rd_ptr_d;
    end else begin
      mem_addr_d = mem_addr_q;
    end
  end

  assign mem_if.mem_req   = mem_req_q;
  assign mem_if.mem_we    = mem_we_q;
  assign mem_if.mem_addr  = mem_addr_q;
  assign mem_if.mem_wdata = mem_wdata_q;
  assign dut_in           = dut_in_q;
  assign busy             = busy_q;
  assign done             = done_q;
  assign err              = err_q;
  assign vec_count        = vec_count_q;

endmodule

// File: doc/gate_test_sequencer.md
# gate_test_sequencer

Sequences one gate-test run of the mini gate tester. It walks the input-vector region of the shared byte memory, reads each stored vector and drives it onto the DUT inputs. After a programmable settle time it samples the DUT outputs and writes the result byte into the output region. It sits between the command/UART front end, which loads vectors and supplies address ranges, and the memory port plus DUT pins. It signals completion so the front end can transmit results.

## Interface
Parameters:
- SETTLE_CYCLES, default 4: cycles between driving `dut_in` and sampling `dut_out`. Legal range 1..255.

Ports:
- `clk` in 1: system clock; all logic on rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: one-cycle pulse that requests a run; sampled only in IDLE.
- `abort` in 1: synchronous abort of a run in progress.
- `in_start_addr` in 16: first input-vector address.
- `in_end_addr` in 16: last input-vector address, inclusive.
- `out_start_addr` in 16: address where the first result byte is written.
- `mem_req` out 1: memory access request; held until acknowledged.
- `mem_we` out 1: 1 = write, 0 = read; valid while `mem_req` = 1.
- `mem_addr` out 16: memory address; valid while `mem_req` = 1.
- `mem_wdata` out 8: write data; valid while `mem_req` = 1 and `mem_we` = 1.
- `mem_rdata` in 8: read data; valid in the cycle `mem_ack` = 1.
- `mem_ack` in 1: one-cycle acknowledge. May be asserted in the same cycle `mem_req` rises.
- `dut_in` out 8: logic inputs to the DUT; held between vectors.
- `dut_out` in 8: logic outputs from the DUT.
- `busy` out 1: high from the accepted start until DONE is left.
- `done` out 1: one-cycle pulse at the end of a completed run.
- `err` out 1: one-cycle pulse when a start is rejected.
- `vec_count` out 16: number of result bytes written in the current or last run.

## Operation
- States: IDLE, READ, SETTLE, WRITE, DONE.
- IDLE: `start` = 1 and `in_end_addr` >= `in_start_addr` (unsigned):
  - latch `rd_ptr` = `in_start_addr`, `wr_ptr` = `out_start_addr`, `end_ptr` = `in_end_addr`;
  - clear `vec_count`, set `busy`, go to READ.
- IDLE: `start` = 1 and `in_end_addr` < `in_start_addr`: pulse `err`, stay in IDLE, leave `busy` = 0 and `vec_count` unchanged.
- READ: `mem_req` = 1, `mem_we` = 0, `mem_addr` = `rd_ptr`. On `mem_ack`:
  - `dut_in` <= `mem_rdata`;
  - load the settle counter with SETTLE_CYCLES;
  - go to SETTLE.
- SETTLE: `mem_req` = 0. The counter decrements each cycle. In the cycle the counter equals 1:
  - `mem_wdata` <= `dut_out`;
  - go to WRITE.
- WRITE: `mem_req` = 1, `mem_we` = 1, `mem_addr` = `wr_ptr`. On `mem_ack`, `vec_count` increments, then:
  - if `rd_ptr` == `end_ptr`, go to DONE;
  - otherwise increment `rd_ptr` and `wr_ptr` and go to READ.
- DONE: pulse `done` for one cycle, clear `busy`, go to IDLE. `dut_in` keeps the last vector.
- Pointer arithmetic is modulo 2^16. `wr_ptr` wraps from 0xFFFF to 0x0000 with no error. The `rd_ptr` compare happens before increment, so `in_end_addr` = 0xFFFF terminates cleanly.
- `start` is ignored while `busy` = 1. The range ports are sampled only at the accepted start; later changes have no effect on the run.
- `abort` (any state except IDLE):
  - next cycle: state IDLE, `mem_req` = 0, `busy` = 0, no `done` pulse;
  - `vec_count` keeps the number of completed writes;
  - an `abort` in the same cycle as `mem_ack` takes priority, so that access's state update is discarded.
- Reset values: state IDLE; `mem_req`, `mem_we`, `busy`, `done`, `err` = 0; `mem_addr`, `mem_wdata`, `vec_count` = 0; `dut_in` = 8'h00.
- Reset mid-run drops `mem_req` asynchronously; no partial write is retried.

## Timing
- Start accepted at edge N, so `mem_req` is high from cycle N+1.
- With zero-wait ack, each vector takes SETTLE_CYCLES + 2 cycles: 1 READ, SETTLE_CYCLES SETTLE, 1 WRITE.
- `dut_in` changes at the edge that samples the read ack. `dut_out` is sampled exactly SETTLE_CYCLES edges later.
- Run of K vectors with zero-wait ack: `done` is high in cycle N + 1 + K·(SETTLE_CYCLES+2).
- Memory wait states stretch READ/WRITE only. `mem_addr`, `mem_we` and `mem_wdata` stay stable while `mem_req` = 1 and `mem_ack` = 0.
- `err` is high in the cycle after the rejected start.

## Test plan
- Single vector, SETTLE_CYCLES=4, zero-wait memory. `mem[0x0010]` = 0xA5, DUT modelled as inverter, range 0x0010..0x0010, `out_start_addr` = 0x0100. Required: `mem[0x0100]` = 0x5A, `done` 7 cycles after start, `vec_count` = 1.
- Four vectors 0x00, 0x01, 0x02, 0x03 at 0x0020..0x0023, DUT = AND of bits 0 and 1. Required: results 0x00, 0x00, 0x00, 0x01 at 0x0200..0x0203, `vec_count` = 4.
- Range 0x0030..0x002F. Required: `err` pulse one cycle, `busy` stays 0, no `mem_req`.
- Memory with 3 wait states on every access. Required:
  - address, `mem_we` and `mem_wdata` stable while waiting;
  - results identical to the zero-wait run;
  - total run length grows by 6 cycles per vector.
- `out_start_addr` = 0xFFFF with 2 vectors. Required: writes go to 0xFFFF then 0x0000, with no error.
- `abort` asserted during SETTLE of vector 2 of 4. Required: `mem_req` = 0 next cycle, `busy` = 0, no `done`, `vec_count` = 1. A new start afterwards runs normally.
